// File: rtl/clint_timer.sv
// Machine timer/software interrupt block: 64-bit mtime/mtimecmp, msip, level irq outputs.
// Response 1 cycle after acceptance; one request outstanding, response held until resp_ready.
module clint_timer #(
    parameter int XLEN     = 32,
    parameter int TICK_DIV = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [15:0]     req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            irq_mtip,
    output logic            irq_msip
);

    localparam bit              IS64     = (XLEN == 64);
    localparam int              DW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0]   DIV_LAST = DW'(TICK_DIV - 1);

    typedef enum logic {IDLE, RESP} state_t;

    state_t          state_q, state_d;
    logic [63:0]     mtime_q, mtime_d;
    logic [63:0]     mtimecmp_q, mtimecmp_d;
    logic            msip_q, msip_d;
    logic [DW-1:0]   div_cnt_q, div_cnt_d;
    logic            accept, tick, aligned, mapped, wr, time_wr;
    logic            sel_msip, sel_cmp_lo, sel_cmp_hi, sel_time_lo, sel_time_hi;
    logic [XLEN-1:0] rdata;

    assign accept = req_valid && req_ready;
    assign tick   = (div_cnt_q == DIV_LAST);

    // Address decode; the high-word offsets only exist on a 32-bit port.
    assign aligned     = IS64 ? (req_addr[2:0] == 3'd0) : (req_addr[1:0] == 2'd0);
    assign sel_msip    = (req_addr == 16'h0000);
    assign sel_cmp_lo  = (req_addr == 16'h4000);
    assign sel_cmp_hi  = !IS64 && (req_addr == 16'h4004);
    assign sel_time_lo = (req_addr == 16'hBFF8);
    assign sel_time_hi = !IS64 && (req_addr == 16'hBFFC);
    assign mapped      = aligned && (sel_msip || sel_cmp_lo || sel_cmp_hi || sel_time_lo || sel_time_hi);
    assign wr          = accept && req_write && mapped;
    assign time_wr     = wr && (sel_time_lo || sel_time_hi);

    always_comb begin
        rdata = '0;
        if (sel_msip)    rdata = XLEN'(msip_q);
        if (sel_cmp_lo)  rdata = mtimecmp_q[XLEN-1:0];
        if (sel_cmp_hi)  rdata = XLEN'(mtimecmp_q[63:32]);
        if (sel_time_lo) rdata = mtime_q[XLEN-1:0];
        if (sel_time_hi) rdata = XLEN'(mtime_q[63:32]);
        if (!mapped)     rdata = '0;
    end

    // A software write to mtime overrides a coincident tick and restarts the prescaler.
    always_comb begin
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        div_cnt_d  = (tick || time_wr) ? '0 : div_cnt_q + DW'(1);
        if (wr) begin
            if (sel_msip)    msip_d     = req_wdata[0];
            if (sel_cmp_lo)  mtimecmp_d = IS64 ? 64'(req_wdata) : {mtimecmp_q[63:32], req_wdata[31:0]};
            if (sel_cmp_hi)  mtimecmp_d = {req_wdata[31:0], mtimecmp_q[31:0]};
            if (sel_time_lo) mtime_d    = IS64 ? 64'(req_wdata) : {mtime_q[63:32], req_wdata[31:0]};
            if (sel_time_hi) mtime_d    = {req_wdata[31:0], mtime_q[31:0]};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            msip_q     <= 1'b0;
            div_cnt_q  <= '0;
            irq_mtip   <= 1'b0;
            irq_msip   <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            div_cnt_q  <= div_cnt_d;
            irq_mtip   <= (mtime_q >= mtimecmp_q);
            irq_msip   <= msip_q;
            if (accept) begin
                resp_rdata <= req_write ? '0 : rdata;
                resp_err   <= !mapped;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)     state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // req_ready is gated by the reset pin so it stays low for the whole reset window.
    always_comb begin
        req_ready  = (state_q == IDLE) && reset;
        resp_valid = (state_q == RESP);
    end

endmodule

// File: tb/tb_clint_timer.sv
module tb_clint_timer;
    localparam int TDIV = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [15:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        irq_mtip;
    logic        irq_msip;

    clint_timer #(.XLEN(32), .TICK_DIV(TDIV)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .irq_mtip(irq_mtip), .irq_msip(irq_msip)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    always @(posedge clock or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Reference model: mtime is the last written value plus elapsed edges / TDIV.
    logic [63:0] mt_base, cmp_m;
    int          mt_edge;
    logic        msip_m;
    logic        exp_mtip = 1'b0, exp_msip = 1'b0;

    function automatic logic [63:0] mtime_at(input int k);
        return mt_base + 64'((k - mt_edge) / TDIV);
    endfunction

    task automatic model_reset();
        mt_base = '0; mt_edge = 0; cmp_m = '1; msip_m = 1'b0;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_access(input logic we, input logic [15:0] a, input logic [31:0] wd,
                                input int w, output logic [31:0] rd, output logic er);
        logic [63:0] cur;
        cur = mtime_at(w - 1);
        rd = '0; er = 1'b0;
        case (a)
            16'h0000: if (we) msip_m = wd[0];           else rd = {31'b0, msip_m};
            16'h4000: if (we) cmp_m[31:0] = wd;         else rd = cmp_m[31:0];
            16'h4004: if (we) cmp_m[63:32] = wd;        else rd = cmp_m[63:32];
            16'hBFF8: if (we) begin mt_base = {cur[63:32], wd}; mt_edge = w; end else rd = cur[31:0];
            16'hBFFC: if (we) begin mt_base = {wd, cur[31:0]};  mt_edge = w; end else rd = cur[63:32];
            default:  er = 1'b1;
        endcase
    endtask

    // Interrupt lines lag the register state by one edge.
    always @(negedge clock) begin
        if (!reset) begin
            exp_mtip = 1'b0; exp_msip = 1'b0;
        end else begin
            check("irq_mtip", irq_mtip, exp_mtip);
            check("irq_msip", irq_msip, exp_msip);
            exp_mtip = (mtime_at(cyc) >= cmp_m);
            exp_msip = msip_m;
        end
    end

    task automatic do_access(input logic we, input logic [15:0] a, input logic [31:0] wd,
                             input int hold, output logic [31:0] rd, output logic er);
        logic [31:0] mrd;
        logic        mer;
        int          n;
        req_valid = 1'b1; req_write = we; req_addr = a; req_wdata = wd;
        resp_ready = (hold == 0);
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clock); n++; end
        check("req_ready_idle", req_ready, 1);
        @(posedge clock); #1;
        req_valid = 1'b0;
        model_access(we, a, wd, cyc, mrd, mer);
        check("resp_valid_latency", resp_valid, 1);
        check("req_ready_busy", req_ready, 0);
        rd = resp_rdata; er = resp_err;
        check("rdata_model", rd, mrd);
        check("err_model", er, mer);
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            check("hold_valid", resp_valid, 1);
            check("hold_rdata", resp_rdata, mrd);
        end
        resp_ready = 1'b1;
        @(posedge clock); #1;
        check("resp_drop", resp_valid, 0);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
        model_reset();
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_rdata", resp_rdata, 0);
        check("rst_err", resp_err, 0);
        check("rst_mtip", irq_mtip, 0);
        check("rst_msip", irq_msip, 0);
        repeat (3) @(negedge clock);
        #2 reset = 1'b1;
        #1 check("rel_req_ready", req_ready, 1);
        @(negedge clock);
    endtask

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t        tbl[16];
    logic [15:0] addrs[8];
    logic [31:0] rd;
    logic        er;
    int          k;

    initial begin
        tbl[0]  = '{0, 16'h4000, 32'h0,        32'hFFFFFFFF, 0};
        tbl[1]  = '{0, 16'h4004, 32'h0,        32'hFFFFFFFF, 0};
        tbl[2]  = '{1, 16'h0000, 32'h1,        32'h0,        0};
        tbl[3]  = '{0, 16'h0000, 32'h0,        32'h1,        0};
        tbl[4]  = '{1, 16'h0000, 32'hFFFFFFFE, 32'h0,        0};
        tbl[5]  = '{0, 16'h0000, 32'h0,        32'h0,        0};
        tbl[6]  = '{0, 16'h0008, 32'h0,        32'h0,        1};
        tbl[7]  = '{0, 16'h4002, 32'h0,        32'h0,        1};
        tbl[8]  = '{1, 16'h4002, 32'h0,        32'h0,        1};
        tbl[9]  = '{1, 16'h0003, 32'h1,        32'h0,        1};
        tbl[10] = '{0, 16'h0000, 32'h0,        32'h0,        0};
        tbl[11] = '{1, 16'h4004, 32'h12345678, 32'h0,        0};
        tbl[12] = '{0, 16'h4004, 32'h0,        32'h12345678, 0};
        tbl[13] = '{0, 16'h4000, 32'h0,        32'hFFFFFFFF, 0};
        tbl[14] = '{0, 16'hBFFD, 32'h0,        32'h0,        1};
        tbl[15] = '{1, 16'h4004, 32'hFFFFFFFF, 32'h0,        0};
        addrs = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC, 16'h0004, 16'h4001, 16'hBFFA};

        do_reset();
        foreach (tbl[i]) begin
            do_access(tbl[i].we, tbl[i].addr, tbl[i].wd, 0, rd, er);
            check($sformatf("tbl%0d_rd", i), rd, tbl[i].exp_rd);
            check($sformatf("tbl%0d_err", i), er, tbl[i].exp_err);
        end

        // Free-running prescaler after reset.
        do_reset();
        repeat (40) @(negedge clock);
        do_access(0, 16'hBFF8, 0, 0, rd, er);
        check("mtime_idle_range", (rd >= 9 && rd <= 11), 1);
        do_access(0, 16'hBFFC, 0, 0, rd, er);
        check("mtime_idle_hi", rd, 0);

        // Compare match: mtime reaches 20 at edge 80, irq follows one edge later.
        do_reset();
        do_access(1, 16'h4004, 32'h0, 0, rd, er);
        do_access(1, 16'h4000, 32'd20, 0, rd, er);
        k = 0;
        while (!irq_mtip && k < 200) begin @(negedge clock); k++; end
        check("mtip_rise_cycle", cyc, 81);
        check("mtip_rise_model", mtime_at(cyc - 1), 20);
        do_access(0, 16'hBFF8, 0, 0, rd, er);
        do_access(1, 16'h4004, 32'h1, 0, rd, er);
        check("mtip_fall", irq_mtip, 0);

        // 64-bit wrap of mtime against an all-ones compare.
        do_access(1, 16'h4000, 32'hFFFFFFFF, 0, rd, er);
        do_access(1, 16'h4004, 32'hFFFFFFFF, 0, rd, er);
        do_access(1, 16'hBFF8, 32'hFFFFFFFF, 0, rd, er);
        do_access(1, 16'hBFFC, 32'hFFFFFFFF, 0, rd, er);
        check("wrap_mtip_set", irq_mtip, 1);
        repeat (4) @(negedge clock);
        check("wrap_mtip_clr", irq_mtip, 0);
        do_access(0, 16'hBFF8, 0, 0, rd, er);
        check("wrap_lo", rd, 0);
        do_access(0, 16'hBFFC, 0, 0, rd, er);
        check("wrap_hi", rd, 0);

        // Response backpressure, then reset with the response still pending.
        do_access(0, 16'h4000, 0, 3, rd, er);
        check("bp_task_rd", rd, 32'hFFFFFFFF);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h4000; resp_ready = 1'b0;
        @(posedge clock); #1;
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("hold5_valid", resp_valid, 1);
            check("hold5_rdata", resp_rdata, 32'hFFFFFFFF);
            check("hold5_req_ready", req_ready, 0);
        end
        #2;
        do_reset();
        do_access(0, 16'h4000, 0, 0, rd, er);
        check("post_rst_cmp", rd, 32'hFFFFFFFF);
        do_access(0, 16'h0000, 0, 0, rd, er);
        check("post_rst_msip", rd, 0);

        // Randomised traffic against the model.
        for (int i = 0; i < 150; i++) begin
            do_access(1'($urandom_range(0, 1)), addrs[$urandom_range(0, 7)], $urandom,
                      $urandom_range(0, 3), rd, er);
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        fails++;
        $display("FAIL global_timeout: simulation did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $fatal(1, "timeout");
    end
endmodule
